// File: rtl/l2_sim_pkg.sv
// l2_sim_pkg: opcode and FSM state enums plus ASCII request codes shared by the L2 request sequencer.
package l2_sim_pkg;
    typedef enum logic [3:0] {
        OP_DR = 4'd0, OP_DW = 4'd1, OP_IR = 4'd2, OP_SI = 4'd3, OP_SR = 4'd4,
        OP_SW = 4'd5, OP_SM = 4'd6, OP_ILL = 4'd7, OP_CLEAR = 4'd8, OP_DUMP = 4'd9
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_PULSE} state_e;
    localparam logic [15:0] L1_DR = 16'h4452;
    localparam logic [15:0] L1_DW = 16'h4457;
    localparam logic [15:0] L1_IR = 16'h4952;
    localparam logic [7:0] SH_I = 8'h49;
    localparam logic [7:0] SH_R = 8'h52;
    localparam logic [7:0] SH_W = 8'h57;
    localparam logic [7:0] SH_M = 8'h4D;
    function automatic logic [15:0] l1_code(input logic [3:0] op);
        return op == OP_DR ? L1_DR : op == OP_DW ? L1_DW : op == OP_IR ? L1_IR : 16'h0;
    endfunction
    function automatic logic [7:0] shared_code(input logic [3:0] op);
        return op == OP_SI ? SH_I : op == OP_SR ? SH_R : op == OP_SW ? SH_W : op == OP_SM ? SH_M : 8'h0;
    endfunction
endpackage

// File: rtl/l2_request_sequencer_if.sv
// l2_request_sequencer_if: trace command handshake and L2 request/response signals.
interface l2_request_sequencer_if #(parameter int ADDR_W = 32);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic              req_valid;
    logic [15:0]       l1_op;
    logic [7:0]        shared_op;
    logic [ADDR_W-1:0] req_addr;
    logic              req_done;
    logic              hit;
    logic              miss;
    modport master (
        input  cmd_valid, cmd_op, cmd_addr, req_done, hit, miss,
        output cmd_ready, req_valid, l1_op, shared_op, req_addr
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_addr, req_done, hit, miss,
        input  cmd_ready, req_valid, l1_op, shared_op, req_addr
    );
endinterface

// File: rtl/request_fifo.sv
// request_fifo: circular command buffer; an extra pointer bit separates full from empty.
module request_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata_o = mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o) wr_q <= wr_q + 1'b1;
            if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
        end
    end
endmodule

// File: rtl/l2_request_sequencer.sv
// l2_request_sequencer: buffers trace commands and issues them one at a time to the L2, keeping statistics.
module l2_request_sequencer
    import l2_sim_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    l2_request_sequencer_if.master bus,
    output logic                   clear_pulse_o,
    output logic                   dump_pulse_o,
    output logic [CNT_W-1:0]       read_count_o,
    output logic [CNT_W-1:0]       write_count_o,
    output logic [CNT_W-1:0]       hit_count_o,
    output logic [CNT_W-1:0]       miss_count_o,
    output logic [CNT_W-1:0]       illegal_count_o,
    output logic                   proto_err_o
);
    localparam int W = 4 + ADDR_W;
    state_e            state_q;
    logic [3:0]        op_q;
    logic              req_valid_q, clear_q, dump_q, proto_q;
    logic [15:0]       l1_q;
    logic [7:0]        sh_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  rd_cnt_q, wr_cnt_q, hit_cnt_q, miss_cnt_q, ill_cnt_q;
    logic [W-1:0]      head;
    logic [3:0]        head_op;
    logic              full, empty, pop;
    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction
    assign head_op       = head[W-1 -: 4];
    assign pop           = state_q == S_IDLE && !empty;
    assign bus.cmd_ready = !full;
    request_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.cmd_valid),
        .pop_i   (pop),
        .wdata_i ({bus.cmd_op, bus.cmd_addr}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            req_valid_q <= 1'b0;
            clear_q     <= 1'b0;
            dump_q      <= 1'b0;
            proto_q     <= 1'b0;
            l1_q        <= '0;
            sh_q        <= '0;
            addr_q      <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            ill_cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (!empty) begin
                    if (head_op <= OP_SM) begin
                        state_q     <= S_ISSUE;
                        req_valid_q <= 1'b1;
                        l1_q        <= l1_code(head_op);
                        sh_q        <= shared_code(head_op);
                        addr_q      <= head[ADDR_W-1:0];
                        op_q        <= head_op;
                    end else if (head_op == OP_CLEAR || head_op == OP_DUMP) begin
                        state_q <= S_PULSE;
                        clear_q <= head_op == OP_CLEAR;
                        dump_q  <= head_op == OP_DUMP;
                    end else ill_cnt_q <= sat(ill_cnt_q);
                end
                S_ISSUE: if (bus.req_done) begin
                    state_q     <= S_IDLE;
                    req_valid_q <= 1'b0;
                    l1_q        <= '0;
                    sh_q        <= '0;
                    if (op_q == OP_DR || op_q == OP_IR) rd_cnt_q <= sat(rd_cnt_q);
                    if (op_q == OP_DW) wr_cnt_q <= sat(wr_cnt_q);
                    // a data access with an ambiguous or absent result counts as a miss
                    if (op_q <= OP_IR) begin
                        if (bus.hit && !bus.miss) hit_cnt_q <= sat(hit_cnt_q);
                        else miss_cnt_q <= sat(miss_cnt_q);
                    end
                    if (bus.hit && bus.miss) proto_q <= 1'b1;
                end
                S_PULSE: begin
                    state_q <= S_IDLE;
                    clear_q <= 1'b0;
                    dump_q  <= 1'b0;
                    if (clear_q) begin
                        rd_cnt_q   <= '0;
                        wr_cnt_q   <= '0;
                        hit_cnt_q  <= '0;
                        miss_cnt_q <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign bus.req_valid   = req_valid_q;
    assign bus.l1_op       = l1_q;
    assign bus.shared_op   = sh_q;
    assign bus.req_addr    = addr_q;
    assign clear_pulse_o   = clear_q;
    assign dump_pulse_o    = dump_q;
    assign read_count_o    = rd_cnt_q;
    assign write_count_o   = wr_cnt_q;
    assign hit_count_o     = hit_cnt_q;
    assign miss_count_o    = miss_cnt_q;
    assign illegal_count_o = ill_cnt_q;
    assign proto_err_o     = proto_q;
endmodule

// File: tb/tb_l2_request_sequencer.sv
// tb_l2_request_sequencer: directed stimulus with a scoreboard of expected requests and pulses,
// checked by a monitor that samples on the falling edge.
module tb_l2_request_sequencer;
    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] l1;
        logic [7:0]  sh;
        logic [31:0] addr;
    } exp_t;
    localparam logic [1:0] K_REQ = 2'd0, K_CLR = 2'd1, K_DMP = 2'd2;

    logic clk = 1'b0, rst = 1'b1;
    logic clear_pulse, dump_pulse, proto_err;
    logic [31:0] read_count, write_count, hit_count, miss_count, illegal_count;
    int checks = 0, errors = 0;
    exp_t exp_q[$];

    l2_request_sequencer_if #(.ADDR_W(32)) bus ();

    l2_request_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .clear_pulse_o   (clear_pulse),
        .dump_pulse_o    (dump_pulse),
        .read_count_o    (read_count),
        .write_count_o   (write_count),
        .hit_count_o     (hit_count),
        .miss_count_o    (miss_count),
        .illegal_count_o (illegal_count),
        .proto_err_o     (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] addr, input bit has_exp, input exp_t e);
        int n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready_timeout", 64'(n < 50), 64'd1);
        if (has_exp) exp_q.push_back(e);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic complete(input logic h, input logic m, input int delay);
        int n = 0;
        while (!bus.req_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_valid_timeout", 64'(n < 50), 64'd1);
        repeat (delay) begin
            @(posedge clk); #1;
        end
        bus.req_done = 1'b1;
        bus.hit      = h;
        bus.miss     = m;
        @(posedge clk); #1;
        bus.req_done = 1'b0;
        bus.hit      = 1'b0;
        bus.miss     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every new request or pulse must match the oldest expectation
    logic prev_rv = 1'b0, prev_clr = 1'b0;
    logic [15:0] held_l1;
    logic [7:0]  held_sh;
    logic [31:0] held_addr;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_rv  = 1'b0;
            prev_clr = 1'b0;
        end else begin
            if (bus.req_valid && !prev_rv) begin
                if (exp_q.size() == 0) check("unexpected_request", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("req_kind", 64'(K_REQ), 64'(e.kind));
                    check("req_l1_op", 64'(bus.l1_op), 64'(e.l1));
                    check("req_shared_op", 64'(bus.shared_op), 64'(e.sh));
                    check("req_addr", 64'(bus.req_addr), 64'(e.addr));
                end
                held_l1   = bus.l1_op;
                held_sh   = bus.shared_op;
                held_addr = bus.req_addr;
            end else if (bus.req_valid) begin
                check("req_stable", {bus.l1_op, bus.shared_op, bus.req_addr}, {held_l1, held_sh, held_addr});
            end else begin
                check("ops_zero_idle", {bus.l1_op, bus.shared_op}, 24'h0);
            end
            if (clear_pulse || dump_pulse) begin
                if (exp_q.size() == 0) check("unexpected_pulse", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", 64'(clear_pulse ? K_CLR : K_DMP), 64'(e.kind));
                end
            end
            check("clear_single_cycle", 64'(clear_pulse && prev_clr), 64'd0);
            prev_rv  = bus.req_valid;
            prev_clr = clear_pulse;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_addr  = '0;
        bus.req_done  = 1'b0;
        bus.hit       = 1'b0;
        bus.miss      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ready_in_reset", 64'(bus.cmd_ready), 64'd1);
        rst = 1'b0;
        idle(1);
        check("rst_req_valid", 64'(bus.req_valid), 64'd0);
        check("rst_counters", {read_count, write_count}, 64'd0);
        check("rst_counters2", {hit_count, miss_count}, 64'd0);
        check("rst_flags", {illegal_count, 29'd0, proto_err, clear_pulse, dump_pulse}, 64'd0);
        check("rst_ready", 64'(bus.cmd_ready), 64'd1);

        // Single data read with hit
        send(4'd0, 32'h0000_1040, 1'b1, '{K_REQ, 16'h4452, 8'h00, 32'h0000_1040});
        check("latency_before", 64'(bus.req_valid), 64'd0);
        idle(1);
        check("latency_valid", 64'(bus.req_valid), 64'd1);
        check("t1_addr", 64'(bus.req_addr), 64'h1040);
        complete(1'b1, 1'b0, 2);
        check("t1_valid_drop", 64'(bus.req_valid), 64'd0);
        check("t1_read", 64'(read_count), 64'd1);
        check("t1_hit", 64'(hit_count), 64'd1);

        // Fill: one in ISSUE plus four buffered blocks further commands
        for (int i = 0; i < 5; i++)
            send(4'd0, 32'h2000 + 32'(i * 64), 1'b1, '{K_REQ, 16'h4452, 8'h00, 32'h2000 + 32'(i * 64)});
        check("t2_full", 64'(bus.cmd_ready), 64'd0);
        idle(3);
        check("t2_held_full", 64'(bus.cmd_ready), 64'd0);
        check("t2_held_addr", 64'(bus.req_addr), 64'h2000);
        complete(1'b1, 1'b0, 0);
        check("t2_idle_gap", 64'(bus.req_valid), 64'd0);
        idle(1);
        check("t2_reopen", 64'(bus.cmd_ready), 64'd1);
        complete(1'b1, 1'b0, 0);
        complete(1'b1, 1'b0, 0);
        complete(1'b0, 1'b1, 1);
        complete(1'b0, 1'b0, 0);
        idle(2);
        check("t2_read", 64'(read_count), 64'd6);
        check("t2_hit", 64'(hit_count), 64'd4);
        check("t2_miss", 64'(miss_count), 64'd2);

        // Snoop, data write, illegal opcode
        send(4'd4, 32'h0000_3000, 1'b1, '{K_REQ, 16'h0000, 8'h52, 32'h0000_3000});
        send(4'd1, 32'h0000_3040, 1'b1, '{K_REQ, 16'h4457, 8'h00, 32'h0000_3040});
        send(4'd12, 32'h0000_3080, 1'b0, '0);
        complete(1'b1, 1'b0, 1);
        complete(1'b1, 1'b0, 1);
        idle(6);
        check("t3_no_third", 64'(bus.req_valid), 64'd0);
        check("t3_write", 64'(write_count), 64'd1);
        check("t3_illegal", 64'(illegal_count), 64'd1);
        check("t3_hit_snoop_ignored", 64'(hit_count), 64'd5);
        check("t3_read", 64'(read_count), 64'd6);

        // Ambiguous result then clear and dump
        send(4'd0, 32'h0000_4000, 1'b1, '{K_REQ, 16'h4452, 8'h00, 32'h0000_4000});
        complete(1'b1, 1'b1, 0);
        idle(1);
        check("t4_miss", 64'(miss_count), 64'd3);
        check("t4_proto", 64'(proto_err), 64'd1);
        send(4'd8, 32'h0, 1'b1, '{K_CLR, 16'h0, 8'h0, 32'h0});
        idle(4);
        check("t4_cleared", {read_count, write_count}, 64'd0);
        check("t4_cleared2", {hit_count, miss_count}, 64'd0);
        check("t4_ill_kept", 64'(illegal_count), 64'd1);
        check("t4_proto_kept", 64'(proto_err), 64'd1);
        send(4'd9, 32'h0, 1'b1, '{K_DMP, 16'h0, 8'h0, 32'h0});
        idle(4);
        check("t4_dump_no_clear", 64'(illegal_count), 64'd1);

        // Reset during ISSUE abandons the request
        send(4'd2, 32'h0000_5000, 1'b1, '{K_REQ, 16'h4952, 8'h00, 32'h0000_5000});
        idle(2);
        check("t5_in_issue", 64'(bus.req_valid), 64'd1);
        rst = 1'b1;
        idle(1);
        check("t5_ready_in_reset", 64'(bus.cmd_ready), 64'd1);
        rst = 1'b0;
        bus.req_done = 1'b1;
        bus.hit      = 1'b1;
        idle(1);
        bus.req_done = 1'b0;
        bus.hit      = 1'b0;
        idle(4);
        check("t5_valid", 64'(bus.req_valid), 64'd0);
        check("t5_counts", {read_count, hit_count}, 64'd0);
        check("t5_counts2", {miss_count, illegal_count}, 64'd0);
        check("t5_proto", 64'(proto_err), 64'd0);
        check("t5_ready", 64'(bus.cmd_ready), 64'd1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
